// File: rtl/ex_mem_latch.sv
// ex_mem_latch -- EX/MEM pipeline register with a multi-cycle mod-exp path.
//
// Ordinary ALU ops (add, sub, pass) are latched into the out_* registers one
// cycle after they are presented. A mod-exp op (alu_ctrl=10) parks its
// destination, control bits and store data in holding registers. The block
// then pulses mod_rst for one cycle and waits for mod_fin. If mod_fin does
// not arrive within MOD_TIMEOUT wait cycles, the result is captured anyway
// and out_err is set.
//
// Handshake: the EX stage offers an instruction with in_valid. The
// instruction is consumed on a rising edge where stall=0. While stall=1,
// upstream must hold in_* steady. stall drops in the mod-exp completion cycle
// so upstream advances on the same edge that captures the result. out_valid
// is a one-cycle strobe per retired instruction and has no back-pressure.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid          EX stage holds a valid instruction
//   alu_ctrl          00 add, 01 sub, 10 mod-exp, 11 pass
//   alu_result, z     ALU result and zero flag
//   mod_fin           mod-exp unit done (level)
//   rd, reg_write, mem_read, mem_write, store_data   fields carried to MEM
//   flush             kill the in-flight instruction
//   out_*             registered MEM-stage copies; out_err = timeout capture
//   stall             combinational upstream hold request
//   mod_rst           registered restart pulse to the mod-exp unit
//   dbg_state         current FSM state (0 IDLE, 1 MOD_START, 2 MOD_WAIT)
module ex_mem_latch #(
   parameter int ARQ         = 16,
   parameter int REG         = 4,
   parameter int MOD_TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   input  logic [1:0]     alu_ctrl,
   input  logic [ARQ-1:0] alu_result,
   input  logic           z,
   input  logic           mod_fin,
   input  logic [REG-1:0] rd,
   input  logic           reg_write,
   input  logic           mem_read,
   input  logic           mem_write,
   input  logic [ARQ-1:0] store_data,
   input  logic           flush,
   output logic           out_valid,
   output logic [ARQ-1:0] out_result,
   output logic           out_z,
   output logic           out_err,
   output logic [REG-1:0] out_rd,
   output logic           out_reg_write,
   output logic           out_mem_read,
   output logic           out_mem_write,
   output logic [ARQ-1:0] out_store_data,
   output logic           stall,
   output logic           mod_rst,
   output logic [1:0]     dbg_state
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOD_START = 2'd1,
      MOD_WAIT  = 2'd2
   } state_t;

   localparam logic [1:0] OP_MODEXP = 2'b10;
   localparam logic [7:0] WCNT_LAST = 8'(MOD_TIMEOUT - 1);

   state_t         state;
   state_t         state_nx;
   logic [7:0]     wcnt;
   logic           timeout;
   logic           done;
   logic           accept_mod;

   // Held copy of the mod-exp instruction; in_* is ignored while waiting.
   logic [REG-1:0] h_rd;
   logic           h_reg_write;
   logic           h_mem_read;
   logic           h_mem_write;
   logic [ARQ-1:0] h_store_data;

   assign dbg_state = state;

   always_comb begin
      timeout    = (state == MOD_WAIT) && (wcnt == WCNT_LAST);
      done       = (state == MOD_WAIT) && (mod_fin || timeout);
      accept_mod = (state == IDLE) && in_valid && (alu_ctrl == OP_MODEXP);
      // Completion releases upstream in the same cycle the result is captured.
      stall      = !rst && (((state != IDLE) && !done) || accept_mod);
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (accept_mod) state_nx = MOD_START;
         MOD_START: state_nx = MOD_WAIT;
         MOD_WAIT:  if (done) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt           <= '0;
         out_valid      <= 1'b0;
         out_result     <= '0;
         out_z          <= 1'b0;
         out_err        <= 1'b0;
         out_rd         <= '0;
         out_reg_write  <= 1'b0;
         out_mem_read   <= 1'b0;
         out_mem_write  <= 1'b0;
         out_store_data <= '0;
         mod_rst        <= 1'b0;
         h_rd           <= '0;
         h_reg_write    <= 1'b0;
         h_mem_read     <= 1'b0;
         h_mem_write    <= 1'b0;
         h_store_data   <= '0;
      end else if (flush) begin
         // Flush beats any capture in the same cycle; data fields keep values.
         out_valid     <= 1'b0;
         out_reg_write <= 1'b0;
         out_mem_read  <= 1'b0;
         out_mem_write <= 1'b0;
         mod_rst       <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         // High exactly for the MOD_START cycle.
         mod_rst   <= (state_nx == MOD_START);
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (alu_ctrl == OP_MODEXP) begin
                     h_rd         <= rd;
                     h_reg_write  <= reg_write;
                     h_mem_read   <= mem_read;
                     h_mem_write  <= mem_write;
                     h_store_data <= store_data;
                  end else begin
                     out_valid      <= 1'b1;
                     out_result     <= alu_result;
                     out_z          <= z;
                     out_err        <= 1'b0;
                     out_rd         <= rd;
                     out_reg_write  <= reg_write;
                     out_mem_read   <= mem_read;
                     out_mem_write  <= mem_write;
                     out_store_data <= store_data;
                  end
               end else begin
                  out_reg_write <= 1'b0;
                  out_mem_read  <= 1'b0;
                  out_mem_write <= 1'b0;
               end
            end
            MOD_START: wcnt <= '0;
            MOD_WAIT: begin
               if (done) begin
                  out_valid      <= 1'b1;
                  out_result     <= alu_result;
                  out_z          <= z;
                  // mod_fin wins a tie with the timeout.
                  out_err        <= !mod_fin;
                  out_rd         <= h_rd;
                  out_reg_write  <= h_reg_write;
                  out_mem_read   <= h_mem_read;
                  out_mem_write  <= h_mem_write;
                  out_store_data <= h_store_data;
               end else begin
                  wcnt <= wcnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mem_latch.sv
// tb_ex_mem_latch -- randomized and directed bench for ex_mem_latch.
// The reference model tracks an outstanding mod-exp op by its age in cycles
// since acceptance (age 1 = restart cycle, age >= 2 = waiting).
module tb_ex_mem_latch;

   localparam int ARQ = 16;
   localparam int REG = 4;
   localparam int TO  = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic [1:0]     alu_ctrl;
   logic [ARQ-1:0] alu_result;
   logic           z;
   logic           mod_fin;
   logic [REG-1:0] rd;
   logic           reg_write;
   logic           mem_read;
   logic           mem_write;
   logic [ARQ-1:0] store_data;
   logic           flush;
   logic           out_valid;
   logic [ARQ-1:0] out_result;
   logic           out_z;
   logic           out_err;
   logic [REG-1:0] out_rd;
   logic           out_reg_write;
   logic           out_mem_read;
   logic           out_mem_write;
   logic [ARQ-1:0] out_store_data;
   logic           stall;
   logic           mod_rst;
   logic [1:0]     dbg_state;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   ex_mem_latch #(.ARQ(ARQ), .REG(REG), .MOD_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .z(z), .mod_fin(mod_fin), .rd(rd),
      .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .store_data(store_data), .flush(flush), .out_valid(out_valid),
      .out_result(out_result), .out_z(out_z), .out_err(out_err),
      .out_rd(out_rd), .out_reg_write(out_reg_write),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_store_data(out_store_data), .stall(stall), .mod_rst(mod_rst),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_errors = 0;
   int mod_rst_cnt = 0;
   int stall_hi_cnt = 0;
   logic obs_stall;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit             m_busy;
   int             m_age;
   logic [REG-1:0] m_rd;
   logic           m_rw, m_mr, m_mw;
   logic [ARQ-1:0] m_sd;
   logic           e_valid, e_z, e_err, e_rw, e_mr, e_mw, e_mod_rst;
   logic [ARQ-1:0] e_result, e_sd;
   logic [REG-1:0] e_rd;

   function automatic logic model_stall();
      if (rst) return 1'b0;
      if (!m_busy) return in_valid && (alu_ctrl == 2'b10);
      if (m_age == 1) return 1'b1;
      return !(mod_fin || (m_age - 2 == TO - 1));
   endfunction

   task automatic model_update();
      bit tmo;
      if (rst) begin
         m_busy = 0; m_age = 0;
         m_rd = '0; m_rw = 0; m_mr = 0; m_mw = 0; m_sd = '0;
         e_valid = 0; e_result = '0; e_z = 0; e_err = 0; e_rd = '0;
         e_rw = 0; e_mr = 0; e_mw = 0; e_sd = '0;
      end else if (flush) begin
         m_busy = 0; e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0;
      end else if (!m_busy) begin
         e_valid = 0;
         if (in_valid && alu_ctrl == 2'b10) begin
            m_busy = 1; m_age = 1;
            m_rd = rd; m_rw = reg_write; m_mr = mem_read; m_mw = mem_write; m_sd = store_data;
         end else if (in_valid) begin
            e_valid = 1; e_result = alu_result; e_z = z; e_err = 0; e_rd = rd;
            e_rw = reg_write; e_mr = mem_read; e_mw = mem_write; e_sd = store_data;
         end else begin
            e_rw = 0; e_mr = 0; e_mw = 0;
         end
      end else if (m_age == 1) begin
         m_age = 2; e_valid = 0;
      end else begin
         tmo = (m_age - 2 == TO - 1);
         e_valid = 0;
         if (mod_fin || tmo) begin
            e_valid = 1; e_result = alu_result; e_z = z; e_err = !mod_fin;
            e_rd = m_rd; e_rw = m_rw; e_mr = m_mr; e_mw = m_mw; e_sd = m_sd;
            m_busy = 0;
         end else begin
            m_age++;
         end
      end
      e_mod_rst = !rst && m_busy && (m_age == 1);
   endtask

   // ---------------- driver tasks ----------------
   // Called shortly after a rising edge with inputs already set; returns
   // one time unit after the next rising edge.
   task automatic step();
      #1;
      check_eq("stall", stall, model_stall());
      obs_stall = stall;
      if (stall === 1'b1) stall_hi_cnt++;
      @(posedge clk);
      model_update();
      #1;
      check_eq("out_valid", out_valid, e_valid);
      check_eq("out_result", out_result, e_result);
      check_eq("out_z", out_z, e_z);
      check_eq("out_err", out_err, e_err);
      check_eq("out_rd", out_rd, e_rd);
      check_eq("out_reg_write", out_reg_write, e_rw);
      check_eq("out_mem_read", out_mem_read, e_mr);
      check_eq("out_mem_write", out_mem_write, e_mw);
      check_eq("out_store_data", out_store_data, e_sd);
      check_eq("mod_rst", mod_rst, e_mod_rst);
      if (mod_rst === 1'b1) mod_rst_cnt++;
   endtask

   task automatic clear_inputs();
      rst = 0; in_valid = 0; alu_ctrl = 2'b00; alu_result = '0; z = 0;
      mod_fin = 0; rd = '0; reg_write = 0; mem_read = 0; mem_write = 0;
      store_data = '0; flush = 0;
   endtask

   task automatic set_op(input logic [1:0] op, input logic [ARQ-1:0] res,
                         input logic [REG-1:0] r, input logic rw);
      clear_inputs();
      in_valid = 1; alu_ctrl = op; alu_result = res; rd = r; reg_write = rw;
      z = (res == '0);
      store_data = 16'hA5A5;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      step();
      rst = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      clear_inputs();
      rst = 1;
      step();
      step();
      // Reset state against constants.
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_result", out_result, 0);
      check_eq("rst_mod_rst", mod_rst, 0);
      check_eq("rst_stall", stall, 0);
      rst = 0;

      // Add pass-through.
      set_op(2'b00, 16'h0005, 4'd3, 1'b1);
      step();
      check_eq("add_valid", out_valid, 1);
      check_eq("add_result", out_result, 16'h0005);
      check_eq("add_rd", out_rd, 3);
      check_eq("add_rw", out_reg_write, 1);
      check_eq("add_stall", obs_stall, 0);
      clear_inputs();
      step();
      check_eq("add_one_shot", out_valid, 0);

      // Mod-exp, mod_fin six cycles after the restart pulse.
      mod_rst_cnt = 0; stall_hi_cnt = 0;
      set_op(2'b10, 16'h1111, 4'd7, 1'b1);
      step();                               // accept
      alu_ctrl = 2'b00; rd = 4'd2;          // must be ignored while waiting
      step();                               // MOD_START
      for (int i = 0; i < 5; i++) step();   // waiting, no mod_fin
      alu_result = 16'h0040; z = 0; mod_fin = 1;
      step();                               // completion
      check_eq("mx_valid", out_valid, 1);
      check_eq("mx_result", out_result, 16'h0040);
      check_eq("mx_rd", out_rd, 7);
      check_eq("mx_err", out_err, 0);
      check_eq("mx_stall_done", obs_stall, 0);
      check_eq("mx_stall_cnt", stall_hi_cnt, 7);
      check_eq("mx_rst_pulses", mod_rst_cnt, 1);
      clear_inputs();
      step();

      // Timeout and simultaneous mod_fin on the timeout cycle.
      for (int k = 0; k < 2; k++) begin
         set_op(2'b10, 16'h0000, 4'd9, 1'b0);
         step();
         clear_inputs();
         alu_result = 16'h0BAD;
         step();
         for (int i = 0; i < TO - 1; i++) step();
         check_eq("to_pending", out_valid, 0);
         mod_fin = (k == 1);
         step();
         check_eq("to_valid", out_valid, 1);
         check_eq("to_err", out_err, (k == 0) ? 1 : 0);
         clear_inputs();
         step();
      end

      // Flush in the second waiting cycle.
      set_op(2'b10, 16'h0000, 4'd5, 1'b1);
      step(); clear_inputs(); step(); step();
      flush = 1; mod_fin = 1;
      step();
      check_eq("fl_valid", out_valid, 0);
      check_eq("fl_rw", out_reg_write, 0);
      clear_inputs();
      step();
      check_eq("fl_stall_after", obs_stall, 0);

      // Reset mid-wait.
      set_op(2'b10, 16'h0000, 4'd6, 1'b1);
      step(); clear_inputs(); step(); step(); step();
      rst = 1; mod_fin = 1; alu_result = 16'hFFFF;
      step();
      check_eq("rw_valid", out_valid, 0);
      check_eq("rw_result", out_result, 0);
      check_eq("rw_rd", out_rd, 0);
      check_eq("rw_sd", out_store_data, 0);
      clear_inputs();
      step();
      check_eq("rw_no_valid", out_valid, 0);

      // Back-to-back sub then add.
      set_op(2'b01, 16'h0003, 4'd1, 1'b1);
      step();
      check_eq("b2b_v1", out_valid, 1);
      check_eq("b2b_r1", out_result, 16'h0003);
      set_op(2'b00, 16'h0009, 4'd2, 1'b1);
      step();
      check_eq("b2b_v2", out_valid, 1);
      check_eq("b2b_r2", out_result, 16'h0009);
      clear_inputs();
      step();

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         alu_ctrl   = 2'($urandom_range(0, 3));
         alu_result = 16'($urandom);
         z          = 1'($urandom_range(0, 1));
         mod_fin    = ($urandom_range(0, 4) == 0);
         rd         = 4'($urandom_range(0, 15));
         reg_write  = 1'($urandom_range(0, 1));
         mem_read   = 1'($urandom_range(0, 1));
         mem_write  = 1'($urandom_range(0, 1));
         store_data = 16'($urandom);
         flush      = ($urandom_range(0, 29) == 0);
         rst        = ($urandom_range(0, 79) == 0);
         step();
      end
      do_reset();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
